// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and default bit periods.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned DIV_25MHZ      = 131;
    localparam int unsigned DIV_32MHZ      = 166;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Per-frame error pulses, registered together so they stay mutually exclusive
    typedef struct packed {
        logic frame_error;
        logic overrun;
    } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready read port of the receive FIFO plus its occupancy count.
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    import uart_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [UART_DATA_BITS-1:0] rd_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [CNT_W-1:0]          fifo_count;

    modport master (
        output rd_data,
        output rd_valid,
        output fifo_count,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        output rd_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    always_comb begin
        w_full       = (r_count == CNT_W'(DEPTH));
        w_pop        = i_pop & r_rd_valid;
        w_push       = i_push & (~w_full | w_pop);
        w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_nxt   = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? i_push_data : r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_rd_data <= w_head_nxt;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;
    assign o_full_c   = w_full;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with programmable bit period, framing check and FWFT receive buffer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = 20,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DIV_WIDTH-1:0] i_clock_divider_value,
    input  logic                 i_rxd,
    uart_rx_fifo_if.master       rd_if,
    output logic                 o_frame_error,
    output logic                 o_overrun
);

    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    logic                      r_sync1;
    logic                      r_sync2;
    rx_state_e                 r_state;
    logic [DIV_WIDTH-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    rx_status_t                r_status;

    rx_state_e                 w_state_nxt;
    logic [DIV_WIDTH-1:0]      w_bit_cnt_nxt;
    logic [IDX_W-1:0]          w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    rx_status_t                w_status_nxt;
    logic                      w_rxs;
    logic                      w_cnt_zero;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_full;
    logic                      w_fifo_valid;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_status  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_status  <= w_status_nxt;
        end
    end

    assign w_pop = rd_if.rd_ready & w_fifo_valid;

    // Half-period countdown lands the start sample mid-bit; full periods thereafter
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_status_nxt  = '0;
        w_push        = 1'b0;
        w_cnt_zero    = (r_bit_cnt == '0);

        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_bit_cnt_nxt = (i_clock_divider_value >> 1) - DIV_WIDTH'(1);
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (!w_cnt_zero) begin
                    w_bit_cnt_nxt = r_bit_cnt - DIV_WIDTH'(1);
                end else if (!w_rxs) begin
                    w_bit_cnt_nxt = i_clock_divider_value - DIV_WIDTH'(1);
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!w_cnt_zero) begin
                    w_bit_cnt_nxt = r_bit_cnt - DIV_WIDTH'(1);
                end else begin
                    w_shift_nxt   = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_cnt_nxt = i_clock_divider_value - DIV_WIDTH'(1);
                    if (r_bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (!w_cnt_zero) begin
                    w_bit_cnt_nxt = r_bit_cnt - DIV_WIDTH'(1);
                end else if (w_rxs) begin
                    if (w_fifo_full && !w_pop) begin
                        w_status_nxt.overrun = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_status_nxt.frame_error = 1'b1;
                    w_state_nxt              = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data (w_shift_nxt),
        .i_pop       (rd_if.rd_ready),
        .o_rd_data   (rd_if.rd_data),
        .o_rd_valid  (w_fifo_valid),
        .o_count     (rd_if.fifo_count),
        .o_full_c    (w_fifo_full)
    );

    assign rd_if.rd_valid = w_fifo_valid;
    assign o_frame_error  = r_status.frame_error;
    assign o_overrun      = r_status.overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receiver for the board-side UART link that the keyboard/terminal path and the simulation bench use to feed characters into `vgaminikbd`. It oversamples an asynchronous 8N1 line at a run-time programmable bit period, checks framing, and buffers received bytes in a first-word-fall-through FIFO with a valid/ready read port toward the character/VGA text logic. It is the receiving end of the existing `uart` transmitter path (`dataInTx`/`dataInTxValid`/`dataInTxBusy`) and must decode its output bit-exactly.

## Interface
- `DIV_WIDTH`, 20, width of `clockDividerValue`.
- `FIFO_DEPTH`, 16, byte entries; power of two, ≥2.
- `clk` input 1: system clock (25 MHz nominal).
- `resetn` input 1: reset, synchronous, active-low.
- `clockDividerValue` input DIV_WIDTH: bit period in clk cycles (131 at 25 MHz); must be ≥4 and held stable while a frame is in progress.
- `rxd` input 1: asynchronous serial line, idle high.
- `rdData` output 8: FIFO head byte; valid only while `rdValid`.
- `rdValid` output 1: FIFO non-empty.
- `rdReady` input 1: consumer pops head when `rdValid & rdReady`.
- `fifoCount` output $clog2(FIFO_DEPTH)+1: bytes stored.
- `frameError` output 1: one-cycle pulse, stop bit sampled low.
- `overrun` output 1: one-cycle pulse, good byte dropped because FIFO full.

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rxs==0` load bit counter with (D>>1)-1 (D = `clockDividerValue`), go START.
- START: count down to 0; at 0 sample `rxs`: 0 → load D-1, bit index 0, go DATA; 1 → glitch, go IDLE, nothing recorded.
- DATA: count down; at 0 shift `rxs` into shift register LSB-first, reload D-1; after bit index 7 go STOP.
- STOP: count down; at 0 sample: 1 → push byte (or pulse `overrun` if full and no same-cycle pop), go IDLE; 0 → pulse `frameError`, discard byte, go BREAK.
- BREAK: wait until `rxs==1`, then IDLE (no new start detected on a held-low line).
- FIFO: push and pop in same cycle when full → both take effect, count unchanged, no overrun. Push and pop when empty → push only (pop not possible, `rdValid`=0). Pointers wrap modulo FIFO_DEPTH.
- `frameError` and `overrun` never assert in the same cycle.

## Timing
- Reset values: FSM IDLE, counters 0, `rdValid` 0, `fifoCount` 0, `rdData` 0, `frameError` 0, `overrun` 0, synchronizer 1s. Reset mid-frame aborts the frame and empties the FIFO; nothing is pushed.
- Let t0 = cycle IDLE sees `rxs==0` (2 cycles after `rxd` falls). Start sample at t0+(D>>1); data bit i at t0+(D>>1)+(i+1)·D; stop sample at t0+(D>>1)+9·D.
- Push occurs on the stop-sample clock edge; `rdValid`/`rdData`/`fifoCount` update the following cycle. Error pulses are asserted the cycle after the stop sample, for exactly one cycle.
- Earliest next start detect: cycle after the stop sample (back-to-back frames with zero idle supported).
- Pop: `rdData` shows next entry the cycle after `rdValid & rdReady`.

## Structure
- Shared package `uart_pkg`: FSM state enum, `UART_DATA_BITS`=8, default divider constants (131 @25 MHz, 166 @32 MHz).
- Sub-module `sync_fifo` (parameterised width/depth, FWFT, count output), reusable by a later TX buffer; FSM, synchronizer and counter live in `uart_rx_fifo`.

## Test plan
- D=131, drive 0x0A from the existing `uart` TX, `rdReady`=1 → single `rdValid` cycle with `rdData`=0x0A, no error pulses.
- 34 back-to-back 0x0A frames, `rdReady`=0, depth 16 → `fifoCount` saturates at 16, `overrun` pulses 18 times, then 16 pops return 0x0A each.
- Frame 0x55 with stop bit forced low, line held low 3·D after → one `frameError`, nothing pushed, no further start until line high, next good 0x41 received correctly.
- `rxd` low for 20 cycles only (D=131) → no push, no error, FSM back to IDLE.
- Assert `resetn`=0 at bit 4 of a frame holding 2 stored bytes → `fifoCount`=0, `rdValid`=0; next frame 0x7E decodes correctly.
- FIFO full, stop sample coincides with pop → `fifoCount` stays 16, no `overrun`, new byte appears last in order.
